fe_sequencer: RTL and testbench
===============================

# fe_sequencer

Parametrised RF front-end sequencer for the WSA receiver. It replaces the tied-off antenna-switch, filter-select and VCO latch-enable outputs with a register-driven controller on the serial settings bus. Each settings write runs a break-before-make switch sequence, waits a programmable settle time, then optionally pulses the VCO latch. While a sequence runs, it blanks the receive path so rx_buffer can discard transient samples.

## Interface
Parameters:
- ADDR, 7'd64, settings address of the control register; ADDR+1 is the status-clear register.
- NUM_SW, 4, number of switch outputs (1..8).
- FILT_W, 2, filter-select width (1..4).
- BREAK_CYC, 2, all-switches-off cycles before the new pattern is applied (≥1).
- LE_CYC, 4, VCO latch-enable pulse length in cycles (≥1).
- LOCK_TMO, 16'd5000, lock-wait timeout in cycles (used only with FE_MUXOUT_LOCK_EN).

Ports:
- clock  in  1  adcclk domain.
- reset_n  in  1  asynchronous, active-low reset.
- serial_addr  in  7  settings bus address.
- serial_data  in  32  settings bus data.
- serial_strobe  in  1  settings bus write strobe, one cycle.
- vco_muxout  in  1  VCO lock detect, asynchronous.
- vsw  out  NUM_SW  antenna/front-end switch drives.
- filt_sel  out  FILT_W  filter bank select.
- vco_le  out  1  VCO latch enable.
- rx_blank  out  1  high while a sequence is active.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at sequence completion.
- status  out  32  readback word for the serial_io readback slot.

## Operation
- Control word written at ADDR:
  - [NUM_SW-1:0] switch pattern.
  - [8+FILT_W-1:8] filter select.
  - [15] latch request.
  - [31:16] settle count S.
- A write to ADDR+1 with bit0 = 1 clears the sticky overrun and lock_fail flags.
- States:
  - IDLE: outputs hold the last applied pattern.
  - BREAK: vsw = 0 for BREAK_CYC cycles. filt_sel holds its previous value.
  - MAKE: vsw and filt_sel take the new values. Lasts 1 cycle.
  - SETTLE: counts S cycles. S = 0 passes straight through in 0 cycles.
  - LATCH: vco_le = 1 for LE_CYC cycles. Entered only if the latch request bit was set.
  - DONE: done = 1. Lasts 1 cycle. Goes to IDLE, or straight to BREAK if a write is pending.
- Write while busy:
  - The word goes to a one-deep pending register.
  - A second write while pending is occupied overwrites it and sets the sticky overrun flag.
- Simultaneous events:
  - Write at ADDR on the same cycle as DONE: the word becomes pending and is taken on the next cycle.
  - Writes to ADDR and ADDR+1 cannot coincide (single bus).
- rx_blank = busy.
- status:
  - [2:0] state encoding.
  - [3] busy.
  - [4] pending valid.
  - [5] overrun.
  - [6] lock_fail.
  - [7] vco_muxout, synchronised.
  - [31:16] remaining settle count.
  - All other bits 0.
- Reset values: vsw = 0, filt_sel = 0, vco_le = 0, rx_blank = 0, busy = 0, done = 0, status = 0, state = IDLE, pending cleared.
- Reset asserted mid-sequence forces these values immediately, without waiting for a clock edge.

## Timing
- Address decode is registered. A strobe at edge n gives busy = 1 and vsw = 0 after edge n+1.
- New vsw and filt_sel appear after edge n+1+BREAK_CYC.
- Minimum sequence (S = 0, no latch): busy for BREAK_CYC+2 cycles, with done in the last of those cycles.
- The settle counter is 16 bit, loaded with S at MAKE and decremented to 0. It does not wrap.
- vco_muxout passes through a 2-flop synchroniser (2-cycle latency).

## Configuration
- FE_MUXOUT_LOCK_EN defined:
  - After the settle count reaches 0, SETTLE also waits for synchronised vco_muxout = 1.
  - If lock does not arrive within LOCK_TMO cycles, lock_fail is set (sticky) and the sequence continues to LATCH/DONE.
- FE_MUXOUT_LOCK_EN undefined:
  - vco_muxout is ignored.
  - status[6] and status[7] read 0.
  - SETTLE ends on the count alone.

## Structure
- Package fe_seq_pkg holds:
  - the state enum (IDLE = 0, BREAK, MAKE, SETTLE, LATCH, DONE);
  - control-word field positions;
  - status bit positions.
- One sub-module, fe_settle_timer: a loadable 16-bit down-counter with zero flag, plus the optional lock-wait/timeout logic.
- Settings-register decode stays in fe_sequencer.

## Test plan
- Reset, then write 32'h0003_0105 at ADDR (vsw = 4'h5, filt = 1, S = 3, no latch):
  - vsw = 0 for 2 cycles, then 5;
  - done 5 cycles later;
  - rx_blank high for exactly 8 cycles.
- Write with bit15 set and S = 0: vco_le high for 4 cycles right after MAKE, then done.
- Three back-to-back writes during a sequence:
  - the 3rd value is applied after the 1st completes;
  - the 2nd is never applied;
  - status[5] = 1 until a write of 1 to ADDR+1.
- reset_n pulled low during SETTLE: all outputs go to 0 immediately, and the sequencer is in IDLE after release.
- With FE_MUXOUT_LOCK_EN and vco_muxout held 0, S = 10: done at 10+LOCK_TMO+BREAK_CYC+2 cycles, and status[6] = 1.
- Write at ADDR on the DONE cycle: BREAK starts on the next cycle, and no IDLE cycle appears.

Source files
------------

// File: rtl/fe_sequencer_pkg.sv
// fe_seq_pkg: shared definitions for the RF front-end sequencer.
//   - fe_state_t  : sequencer state encoding (also read back in status[2:0])
//   - CW_*        : control-word field positions
//   - SB_*        : status-word bit positions
package fe_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BREAK  = 3'd1,
        ST_MAKE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_DONE   = 3'd5
    } fe_state_t;

    // Control word fields (switch pattern always starts at bit 0)
    localparam int CW_FILT_LSB   = 8;
    localparam int CW_LATCH_BIT  = 15;
    localparam int CW_SETTLE_LSB = 16;

    // Status word fields
    localparam int SB_STATE_LSB  = 0;
    localparam int SB_BUSY       = 3;
    localparam int SB_PEND       = 4;
    localparam int SB_OVERRUN    = 5;
    localparam int SB_LOCK_FAIL  = 6;
    localparam int SB_MUXOUT     = 7;
    localparam int SB_SETTLE_LSB = 16;

endpackage

// File: rtl/fe_sequencer_settle_timer.sv
// fe_settle_timer: loadable 16-bit settle down-counter with optional
// VCO lock wait.
//   adcclk, reset_n : clock / asynchronous active-low reset
//   load, load_val  : load the counter (takes priority over run)
//   run             : count down while high; stops at zero, never wraps
//   vco_muxout      : asynchronous lock detect
//   count           : remaining settle count
//   finish          : settle phase may end this cycle
//   lock_timeout    : finishing this cycle because lock never arrived
//   muxout_sync     : synchronised lock detect (0 when lock wait is off)
// Macro FE_MUXOUT_LOCK_EN adds the synchroniser and the lock timeout.
module fe_settle_timer #(
    parameter logic [15:0] LOCK_TMO = 16'd5000
) (
    input  logic        adcclk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        run,
    input  logic        vco_muxout,
    output logic [15:0] count,
    output logic        finish,
    output logic        lock_timeout,
    output logic        muxout_sync
);

    logic [15:0] count_reg;
    logic        zero;

    assign zero  = (count_reg == 16'd0);
    assign count = count_reg;

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (run && !zero) begin
            count_reg <= count_reg - 16'd1;
        end
    end

`ifdef FE_MUXOUT_LOCK_EN
    logic [1:0]  sync_reg;
    logic [15:0] tmo_reg;
    logic        tmo_hit;

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], vco_muxout};
        end
    end

    assign muxout_sync = sync_reg[1];
    // The zero-count cycle is the first lock-wait cycle, so a missing lock
    // costs exactly LOCK_TMO cycles beyond the count.
    assign tmo_hit      = (tmo_reg == LOCK_TMO - 16'd1);
    assign finish       = zero && (muxout_sync || tmo_hit);
    assign lock_timeout = zero && !muxout_sync && tmo_hit;

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_reg <= '0;
        end else if (load) begin
            tmo_reg <= '0;
        end else if (run && zero && !finish) begin
            tmo_reg <= tmo_reg + 16'd1;
        end
    end
`else
    logic        unused_muxout;
    logic [15:0] unused_tmo;

    assign unused_muxout = vco_muxout;
    assign unused_tmo    = LOCK_TMO;
    assign muxout_sync   = 1'b0;
    assign finish        = zero;
    assign lock_timeout  = 1'b0;
`endif

endmodule

// File: rtl/fe_sequencer.sv
// fe_sequencer: register-driven RF front-end switch/filter/VCO-latch sequencer.
//   adcclk, reset_n           : clock / asynchronous active-low reset
//   serial_addr/data/strobe   : settings bus (ADDR = control, ADDR+1 = clear)
//   vco_muxout                : asynchronous VCO lock detect
//   vsw, filt_sel             : switch drives and filter select
//   vco_le                    : VCO latch-enable pulse
//   rx_blank, busy            : high while a sequence runs
//   done                      : one-cycle pulse in the last sequence cycle
//   status                    : readback word
// Optional macro FE_MUXOUT_LOCK_EN: SETTLE additionally waits for VCO lock.
module fe_sequencer
    import fe_seq_pkg::*;
#(
    parameter logic [6:0]  ADDR      = 7'd64,
    parameter int          NUM_SW    = 4,
    parameter int          FILT_W    = 2,
    parameter int          BREAK_CYC = 2,
    parameter int          LE_CYC    = 4,
    parameter logic [15:0] LOCK_TMO  = 16'd5000
) (
    input  logic              adcclk,
    input  logic              reset_n,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              serial_strobe,
    input  logic              vco_muxout,
    output logic [NUM_SW-1:0] vsw,
    output logic [FILT_W-1:0] filt_sel,
    output logic              vco_le,
    output logic              rx_blank,
    output logic              busy,
    output logic              done,
    output logic [31:0]       status
);

    localparam logic [15:0] BREAK_LAST = 16'(BREAK_CYC - 1);
    localparam logic [15:0] LE_LAST    = 16'(LE_CYC - 1);

    // Registered address decode
    logic        wr_ctrl_reg, wr_clr_reg;
    logic [31:0] wr_data_reg;

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ctrl_reg <= 1'b0;
            wr_clr_reg  <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            wr_ctrl_reg <= serial_strobe && (serial_addr == ADDR);
            wr_clr_reg  <= serial_strobe && (serial_addr == ADDR + 7'd1);
            if (serial_strobe) begin
                wr_data_reg <= serial_data;
            end
        end
    end

    logic [NUM_SW-1:0] wr_sw;
    logic [FILT_W-1:0] wr_filt;
    logic              wr_latch;
    logic [15:0]       wr_settle;
    logic              unused_data;

    assign wr_sw       = wr_data_reg[NUM_SW-1:0];
    assign wr_filt     = wr_data_reg[CW_FILT_LSB +: FILT_W];
    assign wr_latch    = wr_data_reg[CW_LATCH_BIT];
    assign wr_settle   = wr_data_reg[CW_SETTLE_LSB +: 16];
    assign unused_data = &{1'b0, wr_data_reg};

    fe_state_t         state_reg;
    logic [15:0]       ph_cnt_reg;
    logic [NUM_SW-1:0] vsw_reg;
    logic [FILT_W-1:0] filt_reg;
    logic              vco_le_reg, busy_reg, done_reg;
    logic [NUM_SW-1:0] cur_sw_reg, pend_sw_reg;
    logic [FILT_W-1:0] cur_filt_reg, pend_filt_reg;
    logic              cur_latch_reg, pend_latch_reg;
    logic [15:0]       cur_settle_reg, pend_settle_reg;
    logic              pend_valid_reg, overrun_reg, lock_fail_reg;

    // A new sequence can start from IDLE or directly out of DONE; a pending
    // word always wins over a write decoded in the same cycle.
    logic can_start, take_pend, take_wr;

    assign can_start = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign take_pend = can_start && pend_valid_reg;
    assign take_wr   = can_start && !pend_valid_reg && wr_ctrl_reg;

    logic [15:0] settle_count;
    logic        settle_finish, lock_timeout, muxout_sync, skip_settle;

    fe_settle_timer #(
        .LOCK_TMO (LOCK_TMO)
    ) u_settle_timer (
        .adcclk       (adcclk),
        .reset_n      (reset_n),
        .load         (state_reg == ST_MAKE),
        .load_val     (cur_settle_reg),
        .run          (state_reg == ST_SETTLE),
        .vco_muxout   (vco_muxout),
        .count        (settle_count),
        .finish       (settle_finish),
        .lock_timeout (lock_timeout),
        .muxout_sync  (muxout_sync)
    );

`ifdef FE_MUXOUT_LOCK_EN
    // With S = 0 the lock wait is still needed unless lock is already present.
    assign skip_settle = (cur_settle_reg == 16'd0) && muxout_sync;
`else
    assign skip_settle = (cur_settle_reg == 16'd0);
`endif

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            ph_cnt_reg      <= '0;
            vsw_reg         <= '0;
            filt_reg        <= '0;
            vco_le_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            cur_sw_reg      <= '0;
            cur_filt_reg    <= '0;
            cur_latch_reg   <= 1'b0;
            cur_settle_reg  <= '0;
            pend_valid_reg  <= 1'b0;
            pend_sw_reg     <= '0;
            pend_filt_reg   <= '0;
            pend_latch_reg  <= 1'b0;
            pend_settle_reg <= '0;
            overrun_reg     <= 1'b0;
            lock_fail_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (take_pend || take_wr) begin
                        state_reg      <= ST_BREAK;
                        busy_reg       <= 1'b1;
                        vsw_reg        <= '0;
                        ph_cnt_reg     <= '0;
                        cur_sw_reg     <= take_pend ? pend_sw_reg     : wr_sw;
                        cur_filt_reg   <= take_pend ? pend_filt_reg   : wr_filt;
                        cur_latch_reg  <= take_pend ? pend_latch_reg  : wr_latch;
                        cur_settle_reg <= take_pend ? pend_settle_reg : wr_settle;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_BREAK: begin
                    if (ph_cnt_reg == BREAK_LAST) begin
                        state_reg <= ST_MAKE;
                        vsw_reg   <= cur_sw_reg;
                        filt_reg  <= cur_filt_reg;
                    end else begin
                        ph_cnt_reg <= ph_cnt_reg + 16'd1;
                    end
                end
                ST_MAKE, ST_SETTLE: begin
                    if ((state_reg == ST_MAKE) ? skip_settle : settle_finish) begin
                        if (cur_latch_reg) begin
                            state_reg  <= ST_LATCH;
                            vco_le_reg <= 1'b1;
                            ph_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_LATCH: begin
                    if (ph_cnt_reg == LE_LAST) begin
                        state_reg  <= ST_DONE;
                        vco_le_reg <= 1'b0;
                        done_reg   <= 1'b1;
                    end else begin
                        ph_cnt_reg <= ph_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    busy_reg   <= 1'b0;
                    vco_le_reg <= 1'b0;
                end
            endcase

            // One-deep pending slot: any control write not consumed directly
            // lands here, overwriting (and flagging) an unconsumed older word.
            if (wr_ctrl_reg && !take_wr) begin
                pend_valid_reg  <= 1'b1;
                pend_sw_reg     <= wr_sw;
                pend_filt_reg   <= wr_filt;
                pend_latch_reg  <= wr_latch;
                pend_settle_reg <= wr_settle;
            end else if (take_pend) begin
                pend_valid_reg <= 1'b0;
            end

            if (wr_ctrl_reg && !take_wr && pend_valid_reg && !take_pend) begin
                overrun_reg <= 1'b1;
            end else if (wr_clr_reg && wr_data_reg[0]) begin
                overrun_reg <= 1'b0;
            end

            if ((state_reg == ST_SETTLE) && lock_timeout) begin
                lock_fail_reg <= 1'b1;
            end else if (wr_clr_reg && wr_data_reg[0]) begin
                lock_fail_reg <= 1'b0;
            end
        end
    end

    assign vsw      = vsw_reg;
    assign filt_sel = filt_reg;
    assign vco_le   = vco_le_reg;
    assign busy     = busy_reg;
    assign rx_blank = busy_reg;
    assign done     = done_reg;

    always_comb begin
        status                          = '0;
        status[SB_STATE_LSB +: 3]       = state_reg;
        status[SB_BUSY]                 = busy_reg;
        status[SB_PEND]                 = pend_valid_reg;
        status[SB_OVERRUN]              = overrun_reg;
        status[SB_LOCK_FAIL]            = lock_fail_reg;
        status[SB_MUXOUT]               = muxout_sync;
        status[SB_SETTLE_LSB +: 16]     = settle_count;
    end

endmodule

// File: tb/tb_fe_sequencer.sv
// Self-checking bench for fe_sequencer: table of control words checked by a
// scoreboard (expected sequence pushed at write, compared at done), plus
// hand-written multi-cycle corner cases. Build with FE_MUXOUT_LOCK_EN to
// include the lock-timeout case.
module tb_fe_sequencer;

    localparam logic [6:0] ADDR     = 7'd64;
    localparam logic [6:0] ADDR_CLR = 7'd65;
`ifdef FE_MUXOUT_LOCK_EN
    localparam logic [31:0] MUX_BIT = 32'h0000_0080;
`else
    localparam logic [31:0] MUX_BIT = 32'h0000_0000;
`endif

    logic        adcclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic        vco_muxout = 1'b1;
    logic [3:0]  vsw;
    logic [1:0]  filt_sel;
    logic        vco_le, rx_blank, busy, done;
    logic [31:0] status;

    fe_sequencer #(
        .ADDR      (ADDR),
        .NUM_SW    (4),
        .FILT_W    (2),
        .BREAK_CYC (2),
        .LE_CYC    (4),
        .LOCK_TMO  (16'd40)
    ) dut (
        .adcclk        (adcclk),
        .reset_n       (reset_n),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .vco_muxout    (vco_muxout),
        .vsw           (vsw),
        .filt_sel      (filt_sel),
        .vco_le        (vco_le),
        .rx_blank      (rx_blank),
        .busy          (busy),
        .done          (done),
        .status        (status)
    );

    always #5 adcclk = ~adcclk;

    typedef struct {
        logic [3:0] sw;
        logic [1:0] filt;
        int         len;
        int         le;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seq_no = 0;

    logic [3:0]  cap_vsw    [0:15];
    logic [1:0]  cap_filt   [0:15];
    logic        cap_blank  [0:15];
    logic        cap_busy   [0:15];
    logic        cap_done   [0:15];
    logic        cap_le     [0:15];
    logic [31:0] cap_status [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] sw, input logic [1:0] f, input int len, input int le);
        exp_t e;
        e.sw = sw; e.filt = f; e.len = len; e.le = le;
        sb_q.push_back(e);
    endtask

    // Strobe is sampled at the first posedge after the call.
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_addr   = a;
        serial_data   = d;
        serial_strobe = 1'b1;
        @(posedge adcclk);
        #1;
        serial_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        repeat (2) @(negedge adcclk);
        while (busy && n < max_cyc) begin
            @(negedge adcclk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", max_cyc);
        end
    endtask

    // Sample index k = cycles after the strobe edge (k = 0 is before it takes effect).
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge adcclk);
            cap_vsw[k]    = vsw;
            cap_filt[k]   = filt_sel;
            cap_blank[k]  = rx_blank;
            cap_busy[k]   = busy;
            cap_done[k]   = done;
            cap_le[k]     = vco_le;
            cap_status[k] = status;
        end
    endtask

    // Scoreboard monitor: measures each busy run up to its done pulse.
    initial begin : monitor
        bit   in_seq;
        int   len, le;
        exp_t e;
        in_seq = 0; len = 0; le = 0;
        forever begin
            @(negedge adcclk);
            if (!reset_n) begin
                in_seq = 0;
            end else if (busy) begin
                if (!in_seq) begin
                    in_seq = 1; len = 0; le = 0;
                end
                len++;
                if (vco_le) le++;
                if (done) begin
                    in_seq = 0;
                    seq_no++;
                    $display("seq %0d: vsw=%h filt=%h len=%0d le=%0d", seq_no, vsw, filt_sel, len, le);
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_unexpected: got sequence vsw=%h, required none", vsw);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_vsw", 32'(vsw), 32'(e.sw));
                        chk("sb_filt", 32'(filt_sel), 32'(e.filt));
                        chk("sb_len", len, e.len);
                        chk("sb_le", le, e.le);
                    end
                end
            end else if (in_seq) begin
                in_seq = 0;
                checks++; errors++;
                $display("FAIL sb_no_done: busy dropped after %0d cycles, required done pulse", len);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[6];
        int   nb, fd, fl, nl;

        vecs[0] = '{32'h0000_000F, '{4'hF, 2'd0, 4, 0}};
        vecs[1] = '{32'h0002_8306, '{4'h6, 2'd3, 11, 4}};
        vecs[2] = '{32'h0001_0009, '{4'h9, 2'd0, 6, 0}};
        vecs[3] = '{32'h0000_0000, '{4'h0, 2'd0, 4, 0}};
        vecs[4] = '{32'h0005_7CF3, '{4'h3, 2'd0, 10, 0}};
        vecs[5] = '{32'h0004_81FE, '{4'hE, 2'd1, 13, 4}};

        // Reset state
        repeat (3) @(negedge adcclk);
        chk("rst_vsw", 32'(vsw), 0);
        chk("rst_filt", 32'(filt_sel), 0);
        chk("rst_vco_le", 32'(vco_le), 0);
        chk("rst_rx_blank", 32'(rx_blank), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_status", status, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge adcclk);

        // Basic sequence: vsw 5, filt 1, S = 3, no latch
        wr(ADDR, 32'h0003_0105);
        push(4'h5, 2'd1, 8, 0);
        capture(12);
        chk("t1_busy_k0", 32'(cap_busy[0]), 0);
        chk("t1_vsw_break1", 32'(cap_vsw[1]), 0);
        chk("t1_vsw_break2", 32'(cap_vsw[2]), 0);
        chk("t1_filt_break", 32'(cap_filt[2]), 0);
        chk("t1_vsw_make", 32'(cap_vsw[3]), 32'h5);
        chk("t1_filt_make", 32'(cap_filt[3]), 32'h1);
        chk("t1_status_break", cap_status[1], 32'h0000_0009 | MUX_BIT);
        chk("t1_status_settle", cap_status[4], 32'h0003_000B | MUX_BIT);
        nb = 0; fd = -1;
        for (int k = 0; k < 12; k++) begin
            if (cap_blank[k]) nb++;
            if (cap_done[k] && fd < 0) fd = k;
        end
        chk("t1_blank_cycles", nb, 8);
        chk("t1_done_cycle", fd, 8);

        // Latch request with S = 0
        wr(ADDR, 32'h0000_820A);
        push(4'hA, 2'd2, 8, 4);
        capture(12);
        chk("t2_filt_held", 32'(cap_filt[1]), 32'h1);
        chk("t2_vsw_make", 32'(cap_vsw[3]), 32'hA);
        fl = -1; nl = 0; fd = -1;
        for (int k = 0; k < 12; k++) begin
            if (cap_le[k]) begin
                nl++;
                if (fl < 0) fl = k;
            end
            if (cap_done[k] && fd < 0) fd = k;
        end
        chk("t2_le_first", fl, 4);
        chk("t2_le_cycles", nl, 4);
        chk("t2_done_cycle", fd, 8);

        // Table-driven sequences
        for (int i = 0; i < 6; i++) begin
            wr(ADDR, vecs[i].data);
            push(vecs[i].exp.sw, vecs[i].exp.filt, vecs[i].exp.len, vecs[i].exp.le);
            wait_idle(200);
        end

        // Three back-to-back writes: 2nd is overwritten by 3rd
        wr(ADDR, 32'h0003_0001);
        wr(ADDR, 32'h0000_0002);
        wr(ADDR, 32'h0000_0104);
        push(4'h1, 2'd0, 8, 0);
        push(4'h4, 2'd1, 4, 0);
        repeat (2) @(negedge adcclk);
        chk("ovr_flags_busy", 32'(status[5:4]), 32'h3);
        wait_idle(100);
        chk("ovr_sticky", 32'(status[5:4]), 32'h2);
        wr(ADDR_CLR, 32'h0000_0000);
        repeat (2) @(negedge adcclk);
        chk("ovr_clear_bit0_zero", 32'(status[5]), 1);
        wr(ADDR_CLR, 32'h0000_0001);
        repeat (2) @(negedge adcclk);
        chk("ovr_cleared", 32'(status[5]), 0);

        // Write decoded on the DONE cycle: BREAK follows with no IDLE gap
        @(negedge adcclk);
        wr(ADDR, 32'h0000_0003);
        push(4'h3, 2'd0, 4, 0);
        push(4'h7, 2'd1, 4, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge adcclk);
            cap_busy[k]   = busy;
            cap_done[k]   = done;
            cap_status[k] = status;
            if (k == 3) begin
                serial_addr   = ADDR;
                serial_data   = 32'h0000_0107;
                serial_strobe = 1'b1;
            end else begin
                serial_strobe = 1'b0;
            end
        end
        nb = 0;
        for (int k = 1; k < 12; k++) begin
            if (!cap_busy[k]) break;
            nb++;
        end
        chk("dw_done_k4", 32'(cap_done[4]), 1);
        chk("dw_break_k5", 32'(cap_status[5][2:0]), 32'h1);
        chk("dw_busy_run", nb, 8);
        wait_idle(50);

        // Asynchronous reset during SETTLE
        wr(ADDR, 32'h0010_0005);
        repeat (6) @(negedge adcclk);
        chk("rs_pre_vsw", 32'(vsw), 32'h5);
        chk("rs_pre_state", 32'(status[2:0]), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_vsw", 32'(vsw), 0);
        chk("rs_filt", 32'(filt_sel), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_rx_blank", 32'(rx_blank), 0);
        chk("rs_status", status, 32'h0);
        repeat (3) @(negedge adcclk);
        reset_n = 1'b1;
        repeat (3) @(negedge adcclk);
        chk("rs_idle_after", 32'(status[3:0]), 32'h0);
        wr(ADDR, 32'h0000_0101);
        push(4'h1, 2'd1, 4, 0);
        wait_idle(50);

`ifdef FE_MUXOUT_LOCK_EN
        // Lock never arrives: S = 10 plus the full timeout
        vco_muxout = 1'b0;
        repeat (4) @(negedge adcclk);
        wr(ADDR, 32'h000A_0001);
        push(4'h1, 2'd0, 10 + 40 + 2 + 2, 0);
        wait_idle(200);
        chk("lk_lock_fail", 32'(status[6]), 1);
        wr(ADDR_CLR, 32'h0000_0001);
        repeat (2) @(negedge adcclk);
        chk("lk_cleared", 32'(status[6]), 0);
        vco_muxout = 1'b1;
        repeat (4) @(negedge adcclk);
`endif

        repeat (4) @(negedge adcclk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
